// File: rtl/line_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_mem_ctrl
// Description : Cache-line fill/writeback controller over a word RAM with a
//               1-cycle registered read port, using a 2-entry read skid FIFO.
// Revision    : 1.0
// ============================================================================
module line_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wdata_last,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_last,
    output logic                  wresp_valid,
    input  logic                  wresp_ready,
    output logic                  wresp_err,
    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic                  mem_r_en,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [DATA_WIDTH-1:0] mem_r_data
);

    localparam int                  c_OFF_BITS  = $clog2(LINE_WORDS);
    localparam logic [c_OFF_BITS-1:0] c_LAST_BEAT = c_OFF_BITS'(LINE_WORDS - 1);
    localparam logic [c_OFF_BITS:0]   c_LINE_CNT  = (c_OFF_BITS + 1)'(LINE_WORDS);
    localparam logic [c_OFF_BITS:0]   c_ISSUE_ONE = (c_OFF_BITS + 1)'(1);
    localparam logic [c_OFF_BITS-1:0] c_BEAT_ONE  = c_OFF_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_WR    = 2'd2,
        S_WRESP = 2'd3
    } state_t;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [ADDR_WIDTH-c_OFF_BITS-1:0] r_base;
    logic [c_OFF_BITS:0]              r_issue_cnt;
    logic [c_OFF_BITS-1:0]            r_beat_cnt;
    logic                             r_inflight;
    logic [DATA_WIDTH-1:0]            r_fifo [2];
    logic                             r_rd_ptr;
    logic                             r_wr_ptr;
    logic [1:0]                       r_count;
    logic                             r_wresp_err;

    logic       w_req_hs;
    logic       w_pop;
    logic       w_fifo_pop;
    logic       w_push;
    logic [2:0] w_occ;
    logic       w_burst_end;
    logic       w_burst_err;
    logic       w_unused_addr_bits;

    assign w_unused_addr_bits = ^req_addr[c_OFF_BITS-1:0];

    // Write burst closes on the marker or on the final word of the line.
    assign w_burst_end = wdata_last || (r_beat_cnt == c_LAST_BEAT);
    assign w_burst_err = wdata_last ^ (r_beat_cnt == c_LAST_BEAT);

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        wresp_valid = 1'b0;
        rdata_valid = 1'b0;
        rdata_last  = 1'b0;
        mem_r_en    = 1'b0;
        mem_w_en    = 1'b0;
        w_req_hs    = 1'b0;
        w_pop       = 1'b0;
        w_occ       = 3'd0;
        // With the FIFO empty the RAM output is forwarded straight through.
        rdata       = (r_count != 2'd0) ? r_fifo[r_rd_ptr] : mem_r_data;
        mem_r_addr  = {r_base, r_issue_cnt[c_OFF_BITS-1:0]};
        mem_w_addr  = {r_base, r_beat_cnt};
        mem_w_data  = wdata;
        wresp_err   = r_wresp_err;

        case (r_state)
            S_IDLE: begin
                req_ready = rst_n;
                w_req_hs  = req_valid && rst_n;
                if (w_req_hs) begin
                    w_state_nxt = req_write ? S_WR : S_RD;
                end
            end
            S_RD: begin
                rdata_valid = (r_count != 2'd0) || r_inflight;
                rdata_last  = rdata_valid && (r_beat_cnt == c_LAST_BEAT);
                w_pop       = rdata_valid && rdata_ready;
                w_occ       = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
                mem_r_en    = (r_issue_cnt < c_LINE_CNT) && (w_occ < 3'd2);
                if (w_pop && rdata_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR: begin
                wdata_ready = 1'b1;
                mem_w_en    = wdata_valid;
                if (wdata_valid && w_burst_end) begin
                    w_state_nxt = S_WRESP;
                end
            end
            S_WRESP: begin
                wresp_valid = 1'b1;
                if (wresp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_fifo_pop = w_pop && (r_count != 2'd0);
    assign w_push     = r_inflight && !(w_pop && (r_count == 2'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_beat_cnt  <= '0;
            r_wresp_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req_hs) begin
                r_base      <= req_addr[ADDR_WIDTH-1:c_OFF_BITS];
                r_issue_cnt <= '0;
                r_beat_cnt  <= '0;
            end else begin
                if (mem_r_en) begin
                    r_issue_cnt <= r_issue_cnt + c_ISSUE_ONE;
                end
                if (w_pop || mem_w_en) begin
                    r_beat_cnt <= r_beat_cnt + c_BEAT_ONE;
                end
            end
            if (mem_w_en && w_burst_end) begin
                r_wresp_err <= w_burst_err;
            end else if (wresp_valid && wresp_ready) begin
                r_wresp_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_inflight <= mem_r_en;
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_fifo_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_fifo_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= mem_r_data;
        end
    end

endmodule
`default_nettype wire
